// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and instruction-fetch sequencer.
// Fetches the word at pc, holds it for decode, commits pc_next_in on handshake.
module pc_fetch_ctrl #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_PC  = '0,
    parameter int                 CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [WIDTH-1:0]     pc,
    input  logic [WIDTH-1:0]     pc_next_in,
    output logic                 imem_req,
    output logic [WIDTH-1:0]     imem_addr,
    input  logic                 imem_ready,
    input  logic                 imem_rvalid,
    input  logic [WIDTH-1:0]     imem_rdata,
    output logic [WIDTH-1:0]     instr,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic                 fault,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                 state;
    logic [WIDTH-1:0]       pc_q;
    logic [WIDTH-1:0]       instr_q;
    logic [CNT_WIDTH-1:0]   retired_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state <= (RESET_PC[1:0] != 2'b00) ? S_FAULT : S_REQ;
                end
                S_REQ: begin
                    if (imem_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr_q <= imem_rdata;
                        state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // The handshake that loads a misaligned target still retires.
                    if (instr_ready) begin
                        pc_q      <= pc_next_in;
                        retired_q <= retired_q + CNT_ONE;
                        state     <= (pc_next_in[1:0] != 2'b00) ? S_FAULT : S_REQ;
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = (state == S_REQ);
    assign instr       = instr_q;
    assign instr_valid = (state == S_HOLD);
    assign fault       = (state == S_FAULT);
    assign retired     = retired_q;

endmodule
